mult_round_apply: RTL and testbench
===================================

// Module: mult_round_apply
// PURPOSE
//  Multi-cycle round-and-normalize stage for the FPU multiplier significand path.
//  Takes the raw 2*SW-bit significand product, sign operands and biased exponent.
//  Derives the sticky (OR of discarded bits) and result sign (XOR of operand signs).
//  Applies directed rounding, renormalizes on carry-out and returns the packed
//  mantissa, exponent and overflow flag via a load/ready/done handshake.
// PARAMETERS
//  SW  24  significand width incl. hidden bit (24 single, 53 double)
//  EW  8   exponent field width (8 single, 11 double)
// PORTS
//  clk         in   1        system clock, rising edge
//  rst         in   1        asynchronous reset, active-low
//  load        in   1        start request; sampled only while ready=1
//  product     in   2*SW     unsigned significand product
//  exp_in      in   EW+1     biased exponent sum; bit EW = overflow guard
//  sign_a      in   1        sign of operand A
//  sign_b      in   1        sign of operand B
//  round_mode  in   2        00 truncate, 01 toward -inf, 10 toward +inf, 11 truncate
//  ready       out  1        1 = IDLE, able to accept load
//  done        out  1        one-cycle pulse: result outputs valid
//  sign_out    out  1        result sign
//  exp_out     out  EW+1     final biased exponent
//  sgf_out     out  SW-1     final mantissa, hidden bit dropped
//  ovf_flag    out  1        exponent overflow: exp_out[EW] | &exp_out[EW-1:0]
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; ready=1; all other outputs 0.
//  FSM, one state per cycle: IDLE -> NORM -> ROUND -> RENORM -> DONE -> IDLE.
//  IDLE: ready=1. On load=1, capture product, exp_in and mode; s=sign_a^sign_b.
//  NORM: if product==0 -> sig=0, sticky=0, exp=0 (zero result, no rounding).
//   elif product[2SW-1]: sig=product[2SW-1:SW]; sticky=|product[SW-1:0]; exp+=1.
//   else: sig=product[2SW-2:SW-1]; sticky=|product[SW-2:0]; exp unchanged.
//  ROUND: inc = sticky & ((mode==01 & s) | (mode==10 & ~s)).
//   sig_r[SW:0] = {1'b0,sig} + inc. Modes 00/11 never increment.
//  RENORM: if sig_r[SW]: sig = sig_r[SW:1] (=100..0), exp+=1; else sig = sig_r[SW-1:0].
//   exp arithmetic is EW+1 bits and wraps modulo 2^(EW+1); no saturation.
//  DONE: register sign_out=s, exp_out, sgf_out=sig[SW-2:0], ovf_flag; done=1.
//  Latency: load sampled at edge k -> done high for the cycle after edge k+4.
//  Result outputs hold until the next DONE. done is never high 2 cycles in a row.
//  ready is 0 in NORM..DONE. load while ready=0 is ignored (no queuing).
//  load in the cycle after DONE (back in IDLE) is accepted normally.
//  Reset asserted mid-operation aborts: return to IDLE, outputs cleared, no done.
//  Underflow and denormals are not handled here; they are handled upstream.
// TESTING
//  1 prod=48'h800000_000000, exp_in=9'h07F, signs 0/0, mode 10
//    -> exp_out=9'h080, sgf_out=0, sign_out=0, ovf=0, done 4 clk after load.
//  2 prod=48'h7FFFFF_800001, exp_in=9'h07F, signs 0/0, mode 10
//    -> sig=FFFFFF+1 carry; exp_out=9'h080, sgf_out=23'h0.
//  3 same product, signs 0/0, mode 01 -> truncate: exp_out=9'h07F, sgf_out=23'h7FFFFF.
//    Signs 1/0, mode 01 -> sign_out=1, exp_out=9'h080, sgf_out=0.
//  4 prod=48'h800000_000000, exp_in=9'h0FE -> exp_out=9'h0FF, ovf_flag=1;
//    product=0 -> exp_out=0, sgf_out=0, ovf_flag=0.
//  5 second load pulsed during NORM/ROUND -> ignored, single done.
//    Back-to-back load right after DONE -> second result 5 clk after first done.
//  6 rst=0 asserted during ROUND -> ready=1, done never pulses, outputs 0.
//    Next load completes normally.

Source files
------------

// File: rtl/mult_round_apply.sv
// Round-and-normalize stage for the FPU multiplier significand path.
// Five-state sequencer: IDLE -> NORM -> ROUND -> RENORM -> DONE -> IDLE.
// Handshake: load is sampled in IDLE only; done pulses for one cycle with the
// registered result, which then holds until the next completed operation.
module mult_round_apply #(
   parameter int SW = 24,
   parameter int EW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [2*SW-1:0] product,
   input  logic [EW:0]     exp_in,
   input  logic            sign_a,
   input  logic            sign_b,
   input  logic [1:0]      round_mode,
   output logic            ready,
   output logic            done,
   output logic            sign_out,
   output logic [EW:0]     exp_out,
   output logic [SW-2:0]   sgf_out,
   output logic            ovf_flag
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_NORM,
      S_ROUND,
      S_RENORM,
      S_DONE
   } state_t;

   state_t          state;
   logic [2*SW-1:0] prod_q;
   logic [EW:0]     exp_q;
   logic [1:0]      mode_q;
   logic            s_q;
   logic            sticky_q;
   // Bit SW holds the rounding carry-out between ROUND and RENORM.
   logic [SW:0]     sig_q;

   logic            prod_zero;
   logic            prod_top;
   logic            sticky_hi;
   logic            sticky_lo;
   logic            inc;
   logic [EW:0]     exp_inc;

   // Normalization and rounding decode from the captured operands.
   always_comb begin
      prod_zero = (prod_q == '0);
      prod_top  = prod_q[2*SW-1];
      sticky_hi = |prod_q[SW-1:0];
      sticky_lo = |prod_q[SW-2:0];
      // Directed rounding only bumps the magnitude when the result moves away
      // from zero: -inf for negatives, +inf for positives. 00/11 truncate.
      inc       = sticky_q & (((mode_q == 2'b01) & s_q) | ((mode_q == 2'b10) & ~s_q));
      // Exponent wraps modulo 2^(EW+1); bit EW flags the overflow downstream.
      exp_inc   = exp_q + (EW+1)'(1);
   end

   // Sequencer with registered datapath and outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         prod_q   <= '0;
         exp_q    <= '0;
         mode_q   <= '0;
         s_q      <= 1'b0;
         sticky_q <= 1'b0;
         sig_q    <= '0;
         ready    <= 1'b1;
         done     <= 1'b0;
         sign_out <= 1'b0;
         exp_out  <= '0;
         sgf_out  <= '0;
         ovf_flag <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (load) begin
                  prod_q <= product;
                  exp_q  <= exp_in;
                  mode_q <= round_mode;
                  s_q    <= sign_a ^ sign_b;
                  ready  <= 1'b0;
                  state  <= S_NORM;
               end
            end
            S_NORM: begin
               if (prod_zero) begin
                  // Exact zero: no rounding can apply, exponent forced to 0.
                  sig_q    <= '0;
                  sticky_q <= 1'b0;
                  exp_q    <= '0;
               end else if (prod_top) begin
                  sig_q    <= {1'b0, prod_q[2*SW-1:SW]};
                  sticky_q <= sticky_hi;
                  exp_q    <= exp_inc;
               end else begin
                  sig_q    <= {1'b0, prod_q[2*SW-2:SW-1]};
                  sticky_q <= sticky_lo;
               end
               state <= S_ROUND;
            end
            S_ROUND: begin
               sig_q <= sig_q + (SW+1)'(inc);
               state <= S_RENORM;
            end
            S_RENORM: begin
               // Carry-out only happens from all-ones, so the shifted value is 100..0.
               if (sig_q[SW]) begin
                  sig_q <= {1'b0, sig_q[SW:1]};
                  exp_q <= exp_inc;
               end
               state <= S_DONE;
            end
            S_DONE: begin
               sign_out <= s_q;
               exp_out  <= exp_q;
               sgf_out  <= sig_q[SW-2:0];
               ovf_flag <= exp_q[EW] | (&exp_q[EW-1:0]);
               done     <= 1'b1;
               ready    <= 1'b1;
               state    <= S_IDLE;
            end
            default: begin
               ready <= 1'b1;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_round_apply.sv
// Directed-vector bench for mult_round_apply (single-precision configuration).
module tb_mult_round_apply;

   localparam int SW = 24;
   localparam int EW = 8;

   logic            clk;
   logic            rst;
   logic            load;
   logic [2*SW-1:0] product;
   logic [EW:0]     exp_in;
   logic            sign_a;
   logic            sign_b;
   logic [1:0]      round_mode;
   logic            ready;
   logic            done;
   logic            sign_out;
   logic [EW:0]     exp_out;
   logic [SW-2:0]   sgf_out;
   logic            ovf_flag;

   int n_vec = 0;
   int n_err = 0;
   int lat;

   mult_round_apply #(.SW(SW), .EW(EW)) dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .product    (product),
      .exp_in     (exp_in),
      .sign_a     (sign_a),
      .sign_b     (sign_b),
      .round_mode (round_mode),
      .ready      (ready),
      .done       (done),
      .sign_out   (sign_out),
      .exp_out    (exp_out),
      .sgf_out    (sgf_out),
      .ovf_flag   (ovf_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Present one operation with load high for exactly one rising edge.
   task automatic start_op(input logic [2*SW-1:0] p, input logic [EW:0] e,
                           input logic sa, input logic sb, input logic [1:0] m);
      product    = p;
      exp_in     = e;
      sign_a     = sa;
      sign_b     = sb;
      round_mode = m;
      load       = 1'b1;
      @(posedge clk);
      #1 load = 1'b0;
   endtask

   // Count edges after the load edge until done; 99 means it never came.
   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 10) begin
         @(posedge clk);
         #1 n++;
      end
      if (!done) n = 99;
   endtask

   task automatic op_chk(input string tag, input logic [2*SW-1:0] p, input logic [EW:0] e,
                         input logic sa, input logic sb, input logic [1:0] m,
                         input logic xs, input logic [EW:0] xe, input logic [SW-2:0] xm,
                         input logic xo);
      int n;
      @(negedge clk);
      start_op(p, e, sa, sb, m);
      chk({tag, ".busy"}, 64'(ready), 64'd0);
      wait_done(n);
      chk({tag, ".lat"}, 64'(n), 64'd4);
      chk({tag, ".sign"}, 64'(sign_out), 64'(xs));
      chk({tag, ".exp"}, 64'(exp_out), 64'(xe));
      chk({tag, ".sgf"}, 64'(sgf_out), 64'(xm));
      chk({tag, ".ovf"}, 64'(ovf_flag), 64'(xo));
      @(posedge clk);
      #1 chk({tag, ".pulse"}, 64'(done), 64'd0);
   endtask

   initial begin
      rst        = 1'b0;
      load       = 1'b0;
      product    = '0;
      exp_in     = '0;
      sign_a     = 1'b0;
      sign_b     = 1'b0;
      round_mode = 2'b00;
      #12;
      chk("rst.ready", 64'(ready), 64'd1);
      chk("rst.done",  64'(done),  64'd0);
      chk("rst.out",   64'({sign_out, exp_out, sgf_out, ovf_flag}), 64'd0);
      @(negedge clk);
      rst = 1'b1;

      // Normalized product, top bit set: exponent bump, no rounding.
      op_chk("v1", 48'h800000_000000, 9'h07F, 1'b0, 1'b0, 2'b10, 1'b0, 9'h080, 23'h0, 1'b0);
      // All-ones significand plus sticky rounds up to carry-out.
      op_chk("v2", 48'h7FFFFF_800001, 9'h07F, 1'b0, 1'b0, 2'b10, 1'b0, 9'h080, 23'h0, 1'b0);
      // Toward -inf on a positive result truncates.
      op_chk("v3a", 48'h7FFFFF_800001, 9'h07F, 1'b0, 1'b0, 2'b01, 1'b0, 9'h07F, 23'h7FFFFF, 1'b0);
      // Toward -inf on a negative result rounds the magnitude up.
      op_chk("v3b", 48'h7FFFFF_800001, 9'h07F, 1'b1, 1'b0, 2'b01, 1'b1, 9'h080, 23'h0, 1'b0);
      // Toward +inf on a negative result truncates; mode 11 truncates.
      op_chk("v3c", 48'h7FFFFF_800001, 9'h07F, 1'b0, 1'b1, 2'b10, 1'b1, 9'h07F, 23'h7FFFFF, 1'b0);
      op_chk("v3d", 48'h7FFFFF_800001, 9'h07F, 1'b1, 1'b1, 2'b11, 1'b0, 9'h07F, 23'h7FFFFF, 1'b0);
      // Mode 00 truncates even with sticky set; top-bit path takes high half.
      op_chk("v3e", 48'hC00001_000001, 9'h010, 1'b1, 1'b0, 2'b00, 1'b1, 9'h011, 23'h400001, 1'b0);
      // Exponent reaching all-ones in the field flags overflow.
      op_chk("v4a", 48'h800000_000000, 9'h0FE, 1'b0, 1'b0, 2'b00, 1'b0, 9'h0FF, 23'h0, 1'b1);
      // Zero product: zero exponent regardless of input exponent.
      op_chk("v4b", 48'h0, 9'h0FE, 1'b1, 1'b0, 2'b10, 1'b1, 9'h000, 23'h0, 1'b0);
      // Guard bit set by the bump flags overflow; full wrap to zero does not.
      op_chk("v4c", 48'h800000_000000, 9'h0FF, 1'b0, 1'b0, 2'b00, 1'b0, 9'h100, 23'h0, 1'b1);
      op_chk("v4d", 48'h800000_000000, 9'h1FF, 1'b0, 1'b0, 2'b00, 1'b0, 9'h000, 23'h0, 1'b0);

      // Extra loads while busy are dropped: one done, first operands win.
      @(negedge clk);
      start_op(48'h800000_000000, 9'h07F, 1'b0, 1'b0, 2'b10);
      product = 48'h0;
      exp_in  = 9'h055;
      load    = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 load = 1'b0;
      wait_done(lat);
      chk("v5.lat", 64'(lat), 64'd2);
      chk("v5.exp", 64'(exp_out), 64'h080);
      lat = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1 if (done) lat++;
      end
      chk("v5.single", 64'(lat), 64'd0);

      // Back-to-back: load in the cycle right after done.
      @(negedge clk);
      start_op(48'h7FFFFF_800001, 9'h07F, 1'b0, 1'b0, 2'b01);
      wait_done(lat);
      chk("v5b.lat1", 64'(lat), 64'd4);
      chk("v5b.sgf1", 64'(sgf_out), 64'h7FFFFF);
      start_op(48'h800000_000000, 9'h0FE, 1'b1, 1'b1, 2'b00);
      wait_done(lat);
      chk("v5b.lat2", 64'(lat + 1), 64'd5);
      chk("v5b.exp2", 64'(exp_out), 64'h0FF);
      chk("v5b.ovf2", 64'(ovf_flag), 64'd1);

      // Reset during ROUND aborts the operation and clears outputs.
      @(negedge clk);
      start_op(48'h7FFFFF_800001, 9'h07F, 1'b1, 1'b0, 2'b01);
      @(posedge clk);
      #1 rst = 1'b0;
      #2;
      chk("v6.ready", 64'(ready), 64'd1);
      chk("v6.out", 64'({done, sign_out, exp_out, sgf_out, ovf_flag}), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      lat = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1 if (done) lat++;
      end
      chk("v6.nodone", 64'(lat), 64'd0);
      chk("v6.hold", 64'({sign_out, exp_out, sgf_out, ovf_flag}), 64'd0);
      op_chk("v6n", 48'h7FFFFF_800001, 9'h07F, 1'b1, 1'b0, 2'b01, 1'b1, 9'h080, 23'h0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
